// File: rtl/clock_system.sv
// Fractional clock generator: three independent phase-accumulator dividers that
// derive MCLK, SMCLK and ACLK from the single sysOsc clock.
module clock_system #(
  parameter int unsigned FPGA_FREQ  = 12_000_000,
  parameter int unsigned MCLK_FREQ  = 1_000_000,
  parameter int unsigned SMCLK_FREQ = 1_000_000,
  parameter int unsigned ACLK_FREQ  = 32_768
) (
  input  logic sysOsc,
  input  logic reset,
  output logic MCLK,
  output logic ACLK,
  output logic SMCLK
);

  localparam int NGEN = 3;
  localparam logic [32:0] FPGA_W = 33'(FPGA_FREQ);
  // Increment is 2*F_out: one accumulator wrap per half-period.
  localparam logic [32:0] INC_W [NGEN] = '{
    {MCLK_FREQ, 1'b0},
    {SMCLK_FREQ, 1'b0},
    {ACLK_FREQ, 1'b0}
  };

  logic [NGEN-1:0] clk_w;

  for (genvar g = 0; g < NGEN; g++) begin : gen_clk
    if (INC_W[g] == 33'd0 || INC_W[g] > FPGA_W) begin : g_bad_freq
      $error("clock_system: output %0d needs 0 < 2*F_out <= FPGA_FREQ", g);
    end

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] sum_w;
    logic        clk_q;
    logic        clk_d;

    always_comb begin
      sum_w = 33'(acc_q) + INC_W[g];
      if (sum_w >= FPGA_W) begin
        acc_d = 32'(sum_w - FPGA_W);
        clk_d = ~clk_q;
      end else begin
        acc_d = sum_w[31:0];
        clk_d = clk_q;
      end
    end

    always_ff @(posedge sysOsc) begin
      if (reset) begin
        acc_q <= 32'd0;
        clk_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        clk_q <= clk_d;
      end
    end

    assign clk_w[g] = clk_q;
  end

  // Outputs are straight flip-flop outputs, no gating.
  assign MCLK  = clk_w[0];
  assign SMCLK = clk_w[1];
  assign ACLK  = clk_w[2];

endmodule

// File: tb/tb_clock_system.sv
// Bench for clock_system: a default-parameter instance and a fast instance
// (FPGA_FREQ=10) checked every cycle against a toggle-count model.
module tb_clock_system;
  timeunit 1ns;
  timeprecision 1ps;

  logic sysOsc = 1'b0;
  logic reset  = 1'b1;
  logic MCLK, ACLK, SMCLK;
  logic MCLK2, ACLK2, SMCLK2;

  int tests_run    = 0;
  int tests_failed = 0;
  longint unsigned n_edges = 0;
  logic [5:0] exp_q[$];

  clock_system dut (
    .sysOsc(sysOsc), .reset(reset), .MCLK(MCLK), .ACLK(ACLK), .SMCLK(SMCLK)
  );

  clock_system #(
    .FPGA_FREQ(10), .MCLK_FREQ(1), .SMCLK_FREQ(2), .ACLK_FREQ(5)
  ) dut_fast (
    .sysOsc(sysOsc), .reset(reset), .MCLK(MCLK2), .ACLK(ACLK2), .SMCLK(SMCLK2)
  );

  always #41.6665 sysOsc = ~sysOsc;

  // After n edges out of reset an output has toggled floor(n*2F/FPGA) times.
  function automatic logic par(longint unsigned n, longint unsigned inc, longint unsigned f);
    return 1'(((n * inc) / f) % 64'd2);
  endfunction

  function automatic logic [5:0] model(longint unsigned n);
    return {par(n, 10, 10), par(n, 4, 10), par(n, 2, 10),
            par(n, 65_536, 12_000_000), par(n, 2_000_000, 12_000_000),
            par(n, 2_000_000, 12_000_000)};
  endfunction

  function automatic logic [5:0] obs();
    return {ACLK2, SMCLK2, MCLK2, ACLK, SMCLK, MCLK};
  endfunction

  task automatic tick();
    @(posedge sysOsc);
    if (reset) n_edges = 0;
    else       n_edges++;
    exp_q.push_back(model(n_edges));
    @(negedge sysOsc);
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL reset_outputs: got %b expected %b", obs(), exp);
      end
    end
    tests_run++;
    if (dut.gen_clk[0].acc_q !== 32'd0 || dut.gen_clk[1].acc_q !== 32'd0 ||
        dut.gen_clk[2].acc_q !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_acc: got %0d %0d %0d expected 0 0 0",
               dut.gen_clk[0].acc_q, dut.gen_clk[1].acc_q, dut.gen_clk[2].acc_q);
    end
  endtask

  task automatic test_startup();
    logic [5:0] exp;
    logic prev_m = 1'b0;
    longint unsigned rise1 = 0, fall1 = 0, rise2 = 0;
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL startup edge %0d: got %b expected %b", n_edges, obs(), exp);
      end
      tests_run++;
      if (MCLK !== SMCLK) begin
        tests_failed++;
        $display("FAIL mclk_eq_smclk edge %0d: MCLK %b SMCLK %b", n_edges, MCLK, SMCLK);
      end
      if (MCLK === 1'b1 && prev_m === 1'b0) begin
        if (rise1 == 0) rise1 = n_edges;
        else if (rise2 == 0) rise2 = n_edges;
      end
      if (MCLK === 1'b0 && prev_m === 1'b1 && fall1 == 0) fall1 = n_edges;
      prev_m = MCLK;
    end
    tests_run++;
    if (rise1 != 6 || fall1 != 12 || rise2 != 18) begin
      tests_failed++;
      $display("FAIL mclk_edges: got rise %0d fall %0d rise %0d expected 6 12 18",
               rise1, fall1, rise2);
    end
  endtask

  task automatic test_fast_param();
    logic [5:0] exp;
    logic prev_a;
    reset = 1'b1;
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs() !== exp) begin
      tests_failed++;
      $display("FAIL fast_reset: got %b expected %b", obs(), exp);
    end
    reset = 1'b0;
    prev_a = ACLK2;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL fast edge %0d: got %b expected %b", n_edges, obs(), exp);
      end
      tests_run++;
      if (ACLK2 !== ~prev_a) begin
        tests_failed++;
        $display("FAIL fast_aclk_toggle edge %0d: got %b expected %b", n_edges, ACLK2, ~prev_a);
      end
      prev_a = ACLK2;
    end
  endtask

  task automatic test_aclk_halfperiods();
    logic [5:0] exp;
    logic prev_a = ACLK;
    logic prev_m = MCLK;
    longint unsigned last_t = 0, sum = 0, hp;
    int halves = -1;
    int m_rises = 0, a_rises = 0, bad_hp = 0;
    for (int i = 0; i < 256 * 184 + 400 && halves < 256; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL aclk_run edge %0d: got %b expected %b", n_edges, obs(), exp);
      end
      if (halves >= 0 && MCLK === 1'b1 && prev_m === 1'b0) m_rises++;
      if (ACLK !== prev_a) begin
        if (halves >= 0) begin
          hp = n_edges - last_t;
          sum += hp;
          if (hp != 183 && hp != 184) bad_hp++;
          if (ACLK === 1'b1) a_rises++;
        end
        last_t = n_edges;
        halves++;
      end
      prev_a = ACLK;
      prev_m = MCLK;
    end
    tests_run++;
    if (halves != 256) begin
      tests_failed++;
      $display("FAIL aclk_halves_seen: got %0d expected 256", halves);
    end
    tests_run++;
    if (bad_hp != 0) begin
      tests_failed++;
      $display("FAIL aclk_halfperiod_range: got %0d out-of-range expected 0", bad_hp);
    end
    tests_run++;
    if (sum != 46_875) begin
      tests_failed++;
      $display("FAIL aclk_halfperiod_sum: got %0d expected 46875", sum);
    end
    tests_run++;
    if (a_rises != 128) begin
      tests_failed++;
      $display("FAIL aclk_rise_count: got %0d expected 128", a_rises);
    end
    tests_run++;
    if (m_rises < 3906 || m_rises > 3907) begin
      tests_failed++;
      $display("FAIL mclk_rise_count: got %0d expected 3906..3907", m_rises);
    end
  endtask

  task automatic test_reset_mid_high();
    logic [5:0] exp;
    int count = 0;
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL midhigh_pre edge %0d: got %b expected %b", n_edges, obs(), exp);
      end
      if (ACLK === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL midhigh_wait: ACLK high not seen within 400 edges");
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      void'(exp_q.pop_front());
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== 6'b0 || exp !== 6'b0) begin
        tests_failed++;
        $display("FAIL midhigh_reset cycle %0d: got %b expected 000000", i, obs());
      end
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      count++;
      exp = exp_q.pop_front();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL midhigh_post edge %0d: got %b expected %b", n_edges, obs(), exp);
      end
      if (ACLK === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen || count != 184) begin
      tests_failed++;
      $display("FAIL aclk_first_rise: got edge %0d expected 184", count);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_fast_param();
    test_aclk_halfperiods();
    test_reset_mid_high();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_system.md
CLOCK_SYSTEM -- requirements
Module: clock_system

Interface
REQ-001 The block SHALL have parameter FPGA_FREQ, default 12_000_000, giving the sysOsc frequency in Hz.
REQ-002 The block SHALL have parameter MCLK_FREQ, default 1_000_000, giving the target MCLK frequency in Hz.
REQ-003 The block SHALL have parameter SMCLK_FREQ, default 1_000_000, giving the target SMCLK frequency in Hz.
REQ-004 The block SHALL have parameter ACLK_FREQ, default 32_768, giving the target ACLK frequency in Hz.
REQ-005 sysOsc  input  1  sole clock (FPGA oscillator); all logic SHALL run on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 MCLK  output  1  master (CPU) clock.
REQ-008 ACLK  output  1  auxiliary low-frequency clock.
REQ-009 SMCLK  output  1  sub-main (peripheral) clock.

Function
REQ-010 Each output SHALL come from its own generator: a 32-bit phase accumulator ACC, an increment INC = 2*F_out, and a registered output bit.
REQ-011 Each rising sysOsc edge without reset: if ACC+INC >= FPGA_FREQ, then ACC <= ACC+INC-FPGA_FREQ and the output toggles; otherwise ACC <= ACC+INC and the output holds.
REQ-012 ACC SHALL always stay in the range 0..FPGA_FREQ-1; sums SHALL be computed at 33 bits so they never overflow.
REQ-013 Each output SHALL come directly from a flip-flop, with no combinational gating, so it is glitch-free.
REQ-014 Average output frequency SHALL equal F_out exactly over any whole number of FPGA_FREQ-cycle periods.
REQ-015 Period jitter SHALL be at most one sysOsc cycle.
REQ-016 When FPGA_FREQ is divisible by 2*F_out, duty cycle SHALL be exactly 50%; otherwise each half-period SHALL be floor or ceil of FPGA_FREQ/(2*F_out) sysOsc cycles.
REQ-017 With the defaults, MCLK and SMCLK SHALL toggle every 6 sysOsc cycles, giving a 12-cycle period and 1 MHz.
REQ-018 With the defaults, ACLK half-periods SHALL be 183 or 184 sysOsc cycles, averaging 183.10546875, giving 32768 Hz.
REQ-019 With equal parameters, MCLK and SMCLK SHALL be bit-identical and edge-aligned.
REQ-020 Elaboration SHALL fail (static assertion) unless every F_out > 0 and 2*F_out <= FPGA_FREQ.
REQ-021 If 2*F_out == FPGA_FREQ, the output SHALL toggle every sysOsc cycle.
REQ-022 The block SHALL have no other inputs; frequencies SHALL be fixed at elaboration.

Reset
REQ-023 While reset is high at a rising sysOsc edge, every ACC SHALL be cleared to 0 and MCLK, SMCLK and ACLK SHALL be driven to 0.
REQ-024 Reset asserted mid-period SHALL take effect at the next rising edge, truncating the current output phase; no partial-pulse suppression is required.
REQ-025 After reset is released, the first toggle of each output SHALL occur on the ceil(FPGA_FREQ/INC)-th rising edge (defaults: MCLK/SMCLK on the 6th, ACLK on the 184th).
REQ-026 Behaviour before the first reset is undefined; the bench SHALL pulse reset first.

Verification
REQ-027 Pulse reset for one cycle -> MCLK=SMCLK=ACLK=0 the following cycle, and all ACC=0.
REQ-028 Defaults, sysOsc period 83.333 ns, run 24 sysOsc cycles after reset -> MCLK rises at edge 6, falls at edge 12, rises at edge 18, and SMCLK==MCLK throughout.
REQ-029 Defaults, simulate 1 s, stop on an ACLK rising edge, count edges -> MCLK 1_000_000 and ACLK 32_768, each within ±1 edge; relative error below 0.01%.
REQ-030 Defaults, record 1000 ACLK half-periods -> each is 183 or 184 sysOsc cycles, and the sum is within 1 cycle of 183105.47.
REQ-031 Assert reset for 3 cycles mid-ACLK-high phase -> all outputs 0 on the next edge; after release, ACLK first rises exactly 184 edges later.
REQ-032 Parameter set FPGA_FREQ=10, ACLK_FREQ=5 -> ACLK toggles every edge; ACLK_FREQ=6 -> elaboration error.
